dff_bank_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit bank of D flip-flops (q/qb storage register) among N requesters. Each requester raises a request, receives an exclusive one-hot grant, loads the register as often as needed while granted, then releases it. A hold limit guarantees fairness. The block sits between requester logic and the shared flip-flop storage, and sequences all writes to it.

---
 rtl/dff_bank_arbiter.sv | 130 +++++++++++++
 tb/tb_dff_bank_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// Round-robin owner arbitration for one shared WIDTH-bit q/qb register bank.
// Handshake: a requester holds req[i] high; gnt[i] answers one edge later and
// stays high until req[i] drops or the hold limit expires. Only the owner's wr
// loads q. The gnt/req pair is a level handshake, not a per-beat valid/ready.
module dff_bank_arbiter #(
    parameter  int N        = 4,
    parameter  int WIDTH    = 8,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         wr,
    input  logic [N*WIDTH-1:0]   din,
    output logic [N-1:0]         gnt,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qb,
    output logic [IDW-1:0]       owner,
    output logic                 busy,
    output logic [1:0]           dbg_state
);
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [HW-1:0]    hold_q, hold_d;

    logic             found;
    logic [IDW-1:0]   sel;
    int               idx;

    // State register: every flop of the block, cleared asynchronously.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            last_q  <= IDW'(N - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic. The scan starts just after the last owner, so the
    // previous owner is always the lowest-priority candidate.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        q_d     = q_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        found   = 1'b0;
        sel     = '0;
        idx     = 0;

        for (int off = 1; off <= N; off++) begin
            idx = (int'(last_q) + off) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << sel;
                    owner_d = sel;
                    last_d  = sel;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                // A dropped request wins over a simultaneous write.
                if (!req[owner_q]) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                end else begin
                    if (wr[owner_q]) begin
                        q_d = din[int'(owner_q)*WIDTH +: WIDTH];
                    end
                    if (hold_q == HOLD_LAST) begin
                        state_d = RELEASE;
                        gnt_d   = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        gnt       = gnt_q;
        q         = q_q;
        qb        = ~q_q;
        owner     = owner_q;
        busy      = (state_q != IDLE);
        dbg_state = state_q;
    end
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench: the driver queues the expected {gnt,q,busy,owner} tuples and
// a monitor pops one each time the observed tuple changes.
module tb_dff_bank_arbiter;
    localparam int N        = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 8;
    localparam int IDW      = 2;
    localparam int TW       = N + WIDTH + 1 + IDW;

    logic                 clk = 1'b0;
    logic                 clear;
    logic [N-1:0]         req;
    logic [N-1:0]         wr;
    logic [N*WIDTH-1:0]   din;
    logic [N-1:0]         gnt;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     qb;
    logic [IDW-1:0]       owner;
    logic                 busy;
    logic [1:0]           dbg_state;

    int tests = 0;
    int fails = 0;
    logic [TW-1:0] exp_q[$];

    dff_bank_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .clear(clear), .req(req), .wr(wr), .din(din),
        .gnt(gnt), .q(q), .qb(qb), .owner(owner), .busy(busy),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    function automatic logic [TW-1:0] pk(input logic [N-1:0] g, input logic [WIDTH-1:0] d,
                                         input logic b, input logic [IDW-1:0] o);
        return {g, d, b, o};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Scoreboard monitor
    initial begin : monitor
        logic [TW-1:0]    prev, cur, e;
        logic [WIDTH-1:0] nq;
        bit               first;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(negedge clk);
            cur = {gnt, q, busy, owner};
            if (first || cur !== prev) begin
                first = 1'b0;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got gnt=%b q=%h busy=%b owner=%0d, expected no change",
                             gnt, q, busy, owner);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        fails++;
                        $display("FAIL sb_tuple: got gnt=%b q=%h busy=%b owner=%0d, expected gnt=%b q=%h busy=%b owner=%0d",
                                 gnt, q, busy, owner,
                                 e[TW-1 -: N], e[IDW+1 +: WIDTH], e[IDW], e[IDW-1:0]);
                    end
                end
                nq = ~q;
                check("qb_complement", 32'(qb), 32'(nq));
                check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            end
            prev = cur;
        end
    end

    // Driver
    initial begin
        logic [WIDTH-1:0] data [5];
        logic [WIDTH-1:0] qprev;
        int o;
        data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44; data[4] = 8'h55;

        // Reset with random inputs, then idle with clear released
        clear = 1'b0;
        req   = 4'($urandom_range(0, 15));
        wr    = 4'($urandom_range(0, 15));
        din   = $urandom;
        exp_q.push_back(pk(4'b0000, 8'h00, 1'b0, 2'd0));
        repeat (3) begin
            step();
            req = 4'($urandom_range(0, 15));
            wr  = 4'($urandom_range(0, 15));
            din = $urandom;
        end
        #1;
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_q", 32'(q), 32'h00);
        check("reset_qb", 32'(qb), 32'hFF);
        check("reset_busy", 32'(busy), 32'h0);
        step();
        clear = 1'b1; req = '0; wr = '0; din = '0;
        repeat (5) step();
        check("idle_stable", 32'({gnt, q, qb, busy}), 32'({4'b0000, 8'h00, 8'hFF, 1'b0}));

        // Single requester 1: grant, one write, drop
        exp_q.push_back(pk(4'b0010, 8'h00, 1'b1, 2'd1));
        exp_q.push_back(pk(4'b0010, 8'hA5, 1'b1, 2'd1));
        exp_q.push_back(pk(4'b0000, 8'hA5, 1'b1, 2'd1));
        exp_q.push_back(pk(4'b0000, 8'hA5, 1'b0, 2'd1));
        req = 4'b0010;
        step();
        wr = 4'b0010; din[15:8] = 8'hA5;
        step();
        wr = '0; req = '0;
        repeat (3) step();

        // Clear pulse in IDLE restores the priority pointer and q
        exp_q.push_back(pk(4'b0000, 8'h00, 1'b0, 2'd0));
        #1 clear = 1'b0;
        #2 clear = 1'b1;
        step();

        // Round-robin: all request, each owner writes once then drops
        qprev = 8'h00;
        for (int k = 0; k < 5; k++) begin
            o = k % N;
            exp_q.push_back(pk(4'(1 << o), qprev,   1'b1, 2'(o)));
            exp_q.push_back(pk(4'(1 << o), data[k], 1'b1, 2'(o)));
            exp_q.push_back(pk(4'b0000,    data[k], 1'b1, 2'(o)));
            exp_q.push_back(pk(4'b0000,    data[k], 1'b0, 2'(o)));
            qprev = data[k];
        end
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            o = k % N;
            wr = '0; wr[o] = 1'b1; din[o*WIDTH +: WIDTH] = data[k];
            step();
            wr = '0; req[o] = 1'b0;
            step();
            if (k < 4) req[o] = 1'b1;
            else       req = '0;
            step();
            step();
        end

        // Forced release after MAX_HOLD grant edges, then re-grant
        exp_q.push_back(pk(4'b0001, 8'h55, 1'b1, 2'd0));
        for (int k = 1; k < 8; k++) exp_q.push_back(pk(4'b0001, 8'(8'hC0 + k), 1'b1, 2'd0));
        exp_q.push_back(pk(4'b0000, 8'hC8, 1'b1, 2'd0));
        exp_q.push_back(pk(4'b0000, 8'hC8, 1'b0, 2'd0));
        exp_q.push_back(pk(4'b0001, 8'hC8, 1'b1, 2'd0));
        exp_q.push_back(pk(4'b0000, 8'hC8, 1'b1, 2'd0));
        exp_q.push_back(pk(4'b0000, 8'hC8, 1'b0, 2'd0));
        req = 4'b0001;
        step();
        for (int k = 1; k <= 8; k++) begin
            wr = 4'b0001; din[7:0] = 8'(8'hC0 + k);
            step();
        end
        wr = '0;
        step();
        step();
        req = '0;
        repeat (3) step();

        // Non-owner writes ignored; drop with owner write discards data
        exp_q.push_back(pk(4'b0100, 8'hC8, 1'b1, 2'd2));
        exp_q.push_back(pk(4'b0100, 8'hD2, 1'b1, 2'd2));
        exp_q.push_back(pk(4'b0000, 8'hD2, 1'b1, 2'd2));
        exp_q.push_back(pk(4'b0000, 8'hD2, 1'b0, 2'd2));
        req = 4'b0100;
        step();
        wr = 4'b1011; din = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        step();
        check("nonowner_ignored", 32'(q), 32'hC8);
        wr = 4'b1111;
        step();
        wr = 4'b0100; din[23:16] = 8'hEE; req = '0;
        repeat (3) step();
        check("drop_write_discarded", 32'(q), 32'hD2);

        // Async clear in grant cycle 3, then requester 0 wins
        exp_q.push_back(pk(4'b0010, 8'hD2, 1'b1, 2'd1));
        exp_q.push_back(pk(4'b0010, 8'h77, 1'b1, 2'd1));
        exp_q.push_back(pk(4'b0001, 8'h00, 1'b1, 2'd0));
        exp_q.push_back(pk(4'b0000, 8'h00, 1'b1, 2'd0));
        exp_q.push_back(pk(4'b0000, 8'h00, 1'b0, 2'd0));
        req = 4'b0010; wr = '0;
        step();
        wr = 4'b0010; din[15:8] = 8'h77;
        step();
        wr = '0;
        step();
        req = 4'b0011;
        #1 clear = 1'b0;
        #1;
        check("async_clear_gnt", 32'(gnt), 32'h0);
        check("async_clear_q", 32'(q), 32'h00);
        check("async_clear_qb", 32'(qb), 32'hFF);
        check("async_clear_busy", 32'(busy), 32'h0);
        #1 clear = 1'b1;
        step();
        req = '0;
        repeat (3) step();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
